// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// State, access-width and grant encodings.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;
    localparam logic [1:0] WIDTH_RSVD = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and RAM-side signals of the arbiter.
// slave = arbiter view, master = requesters plus RAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] instr_address;
    logic              instr_read;
    logic [DATA_W-1:0] instr_value;
    logic              instr_ready;

    logic [ADDR_W-1:0] data_address;
    logic [1:0]        data_width;
    logic              data_read;
    logic              data_write;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_ready;
    logic              data_error;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [3:0]        mem_byte_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  instr_address,
        input  instr_read,
        output instr_value,
        output instr_ready,
        input  data_address,
        input  data_width,
        input  data_read,
        input  data_write,
        input  data_in,
        output data_out,
        output data_ready,
        output data_error,
        output mem_address,
        output mem_read,
        output mem_write,
        output mem_byte_en,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport master (
        output instr_address,
        output instr_read,
        input  instr_value,
        input  instr_ready,
        output data_address,
        output data_width,
        output data_read,
        output data_write,
        output data_in,
        input  data_out,
        input  data_ready,
        input  data_error,
        input  mem_address,
        input  mem_read,
        input  mem_write,
        input  mem_byte_en,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication, byte enables,
// load shift/zero-extend and misalignment detection.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  width_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [31:0] rsh;

    always_comb begin
        rsh       = rdata_i >> {addr_lo_i, 3'b000};
        byte_en_o = 4'b0000;
        wdata_o   = wdata_i;
        rdata_o   = rsh;
        case (width_i)
            WIDTH_BYTE: begin
                byte_en_o = 4'b0001 << addr_lo_i;
                wdata_o   = {4{wdata_i[7:0]}};
                rdata_o   = {24'h0, rsh[7:0]};
            end
            WIDTH_HALF: begin
                byte_en_o = 4'b0011 << addr_lo_i;
                wdata_o   = {2{wdata_i[15:0]}};
                rdata_o   = {16'h0, rsh[15:0]};
            end
            WIDTH_WORD: begin
                byte_en_o = 4'b1111;
            end
            default: begin
                byte_en_o = 4'b0000;
            end
        endcase
    end

    assign misaligned_o =
        (width_i == WIDTH_RSVD) |
        ((width_i == WIDTH_HALF) & addr_lo_i[0]) |
        ((width_i == WIDTH_WORD) & (|addr_lo_i));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-RAM arbiter for fetch and load/store ports, registered outputs.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic              clock,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        width_q, width_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ivalue_q, ivalue_d;
    logic              iready_q, iready_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dready_q, dready_d;
    logic              derror_q, derror_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_e            last_q, last_d;
`endif

    logic        instr_req;
    logic        data_req;
    logic        pick_data;
    logic [1:0]  al_addr;
    logic [1:0]  al_width;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_mis;

    assign instr_req = bus.instr_read;
    assign data_req  = bus.data_read | bus.data_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign pick_data = data_req &
        (~instr_req | (last_q == GRANT_INSTR));
`else
    assign pick_data = data_req;
`endif

    // IDLE steers the live request; later states use the latched copy
    assign al_addr  = (state_q == IDLE) ? bus.data_address[1:0]
                                        : addr_q[1:0];
    assign al_width = (state_q == IDLE) ? bus.data_width : width_q;

    mem_lane_align u_align (
        .addr_lo_i    (al_addr),
        .width_i      (al_width),
        .wdata_i      (bus.data_in),
        .rdata_i      (bus.mem_rdata),
        .byte_en_o    (al_be),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_mis)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        addr_d        = addr_q;
        width_d       = width_q;
        mem_address_d = mem_address_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        be_d          = be_q;
        wdata_d       = wdata_q;
        ivalue_d      = ivalue_q;
        iready_d      = 1'b0;
        dout_d        = dout_q;
        dready_d      = 1'b0;
        derror_d      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d        = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_data) begin
                    grant_d       = GRANT_DATA;
                    addr_d        = bus.data_address;
                    width_d       = bus.data_width;
                    mem_address_d = {bus.data_address[ADDR_W-1:2], 2'b00};
                    be_d          = al_be;
                    wdata_d       = al_wdata;
                    if (al_mis) begin
                        state_d  = RESP;
                        derror_d = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_write_d = bus.data_write;
                        mem_read_d  = ~bus.data_write;
                    end
                end else if (instr_req) begin
                    grant_d       = GRANT_INSTR;
                    addr_d        = bus.instr_address;
                    width_d       = WIDTH_WORD;
                    mem_address_d = {bus.instr_address[ADDR_W-1:2], 2'b00};
                    state_d       = ISSUE;
                    mem_read_d    = 1'b1;
                end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (instr_req | data_req) begin
                    last_d = grant_d;
                end
`endif
            end
            ISSUE: begin
                if (mem_write_q) begin
                    state_d  = RESP;
                    dready_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    state_d = RESP;
                    if (grant_q == GRANT_INSTR) begin
                        ivalue_d = bus.mem_rdata;
                        iready_d = 1'b1;
                    end else begin
                        dout_d   = al_rdata;
                        dready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= GRANT_INSTR;
            addr_q        <= '0;
            width_q       <= WIDTH_BYTE;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            be_q          <= 4'b0000;
            wdata_q       <= '0;
            ivalue_q      <= '0;
            iready_q      <= 1'b0;
            dout_q        <= '0;
            dready_q      <= 1'b0;
            derror_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q        <= GRANT_INSTR;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            addr_q        <= addr_d;
            width_q       <= width_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            ivalue_q      <= ivalue_d;
            iready_q      <= iready_d;
            dout_q        <= dout_d;
            dready_q      <= dready_d;
            derror_q      <= derror_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q        <= last_d;
`endif
        end
    end

    assign bus.instr_value = ivalue_q;
    assign bus.instr_ready = iready_q;
    assign bus.data_out    = dout_q;
    assign bus.data_ready  = dready_q;
    assign bus.data_error  = derror_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_byte_en = be_q;
    assign bus.mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (both MEM_ARB_ROUND_ROBIN_EN builds).
module tb_mem_port_arbiter;

    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic [3:0] ARB_SEQ = 4'b0101;
`else
    localparam logic [3:0] ARB_SEQ = 4'b1111;
`endif

    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".mem_read"},    64'(bus.mem_read),    64'h0);
        chk({tag, ".mem_write"},   64'(bus.mem_write),   64'h0);
        chk({tag, ".mem_address"}, 64'(bus.mem_address), 64'h0);
        chk({tag, ".mem_byte_en"}, 64'(bus.mem_byte_en), 64'h0);
        chk({tag, ".mem_wdata"},   64'(bus.mem_wdata),   64'h0);
        chk({tag, ".instr_ready"}, 64'(bus.instr_ready), 64'h0);
        chk({tag, ".instr_value"}, 64'(bus.instr_value), 64'h0);
        chk({tag, ".data_ready"},  64'(bus.data_ready),  64'h0);
        chk({tag, ".data_error"},  64'(bus.data_error),  64'h0);
        chk({tag, ".data_out"},    64'(bus.data_out),    64'h0);
    endtask

    initial begin
        reset             = 1'b1;
        bus.instr_address = '0;
        bus.instr_read    = 1'b0;
        bus.data_address  = '0;
        bus.data_width    = 2'd0;
        bus.data_read     = 1'b0;
        bus.data_write    = 1'b0;
        bus.data_in       = '0;
        bus.mem_rdata     = '0;
        bus.mem_ready     = 1'b0;
        step;
        step;
        reset = 1'b0;
        step;
        chk_zero("reset");

        // fetch 0x100, RAM always ready
        bus.mem_rdata     = 32'h0000_0013;
        bus.mem_ready     = 1'b1;
        bus.instr_address = 32'h100;
        bus.instr_read    = 1'b1;
        step;
        chk("fetch.c1.mem_read", 64'(bus.mem_read), 64'h1);
        chk("fetch.c1.mem_write", 64'(bus.mem_write), 64'h0);
        chk("fetch.c1.addr", 64'(bus.mem_address), 64'h100);
        step;
        chk("fetch.c2.mem_read", 64'(bus.mem_read), 64'h0);
        chk("fetch.c2.ready", 64'(bus.instr_ready), 64'h0);
        step;
        chk("fetch.c3.ready", 64'(bus.instr_ready), 64'h1);
        chk("fetch.c3.value", 64'(bus.instr_value), 64'h13);
        bus.instr_read = 1'b0;
        step;
        chk("fetch.c4.ready", 64'(bus.instr_ready), 64'h0);

        // byte store 0xAB to 0x203
        bus.data_address = 32'h203;
        bus.data_width   = 2'd0;
        bus.data_in      = 32'h0000_00AB;
        bus.data_write   = 1'b1;
        step;
        chk("sb.c1.mem_write", 64'(bus.mem_write), 64'h1);
        chk("sb.c1.mem_read", 64'(bus.mem_read), 64'h0);
        chk("sb.c1.be", 64'(bus.mem_byte_en), 64'h8);
        chk("sb.c1.wdata", 64'(bus.mem_wdata), 64'hABAB_ABAB);
        chk("sb.c1.addr", 64'(bus.mem_address), 64'h200);
        chk("sb.c1.ready", 64'(bus.data_ready), 64'h0);
        step;
        chk("sb.c2.ready", 64'(bus.data_ready), 64'h1);
        chk("sb.c2.mem_write", 64'(bus.mem_write), 64'h0);
        bus.data_write = 1'b0;
        step;
        chk("sb.c3.ready", 64'(bus.data_ready), 64'h0);

        // half store 0xBEEF to 0x202
        bus.data_address = 32'h202;
        bus.data_width   = 2'd1;
        bus.data_in      = 32'h1234_BEEF;
        bus.data_write   = 1'b1;
        step;
        chk("sh.c1.be", 64'(bus.mem_byte_en), 64'hC);
        chk("sh.c1.wdata", 64'(bus.mem_wdata), 64'hBEEF_BEEF);
        step;
        chk("sh.c2.ready", 64'(bus.data_ready), 64'h1);
        bus.data_write = 1'b0;
        step;

        // half load from 0x202
        bus.mem_rdata    = 32'h1234_5678;
        bus.data_address = 32'h202;
        bus.data_width   = 2'd1;
        bus.data_read    = 1'b1;
        step;
        chk("lh.c1.mem_read", 64'(bus.mem_read), 64'h1);
        step;
        chk("lh.c2.ready", 64'(bus.data_ready), 64'h0);
        step;
        chk("lh.c3.ready", 64'(bus.data_ready), 64'h1);
        chk("lh.c3.data", 64'(bus.data_out), 64'h1234);
        bus.data_read = 1'b0;
        step;

        // misaligned half load from 0x201
        bus.data_address = 32'h201;
        bus.data_read    = 1'b1;
        step;
        chk("lh201.c1.error", 64'(bus.data_error), 64'h1);
        chk("lh201.c1.ready", 64'(bus.data_ready), 64'h0);
        chk("lh201.c1.mem_read", 64'(bus.mem_read), 64'h0);
        chk("lh201.c1.mem_write", 64'(bus.mem_write), 64'h0);
        bus.data_read = 1'b0;
        step;
        chk("lh201.c2.error", 64'(bus.data_error), 64'h0);
        chk("lh201.c2.mem_read", 64'(bus.mem_read), 64'h0);

        // misaligned word store and reserved width
        bus.data_address = 32'h206;
        bus.data_width   = 2'd2;
        bus.data_write   = 1'b1;
        step;
        chk("sw206.error", 64'(bus.data_error), 64'h1);
        chk("sw206.mem_write", 64'(bus.mem_write), 64'h0);
        bus.data_write = 1'b0;
        step;
        bus.data_address = 32'h300;
        bus.data_width   = 2'd3;
        bus.data_read    = 1'b1;
        step;
        chk("rsvd.error", 64'(bus.data_error), 64'h1);
        chk("rsvd.mem_read", 64'(bus.mem_read), 64'h0);
        bus.data_read = 1'b0;
        step;

        // simultaneous fetch and load, fresh arbitration history
        reset = 1'b1;
        step;
        reset = 1'b0;
        step;
        bus.mem_rdata     = 32'h0000_0055;
        bus.mem_ready     = 1'b1;
        bus.instr_address = 32'h300;
        bus.data_address  = 32'h400;
        bus.data_width    = 2'd2;
        bus.instr_read    = 1'b1;
        bus.data_read     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            chk($sformatf("arb%0d.mem_read", i),
                64'(bus.mem_read), 64'h1);
            chk($sformatf("arb%0d.addr", i), 64'(bus.mem_address),
                ARB_SEQ[i] ? 64'h400 : 64'h300);
            step;
            step;
            chk($sformatf("arb%0d.dready", i),
                64'(bus.data_ready), 64'(ARB_SEQ[i]));
            chk($sformatf("arb%0d.iready", i),
                64'(bus.instr_ready), 64'(!ARB_SEQ[i]));
            if (i == 3) begin
                bus.instr_read = 1'b0;
                bus.data_read  = 1'b0;
            end
            step;
        end

        // RAM stalls for 5 cycles in WAIT
        bus.mem_ready    = 1'b0;
        bus.data_address = 32'h500;
        bus.data_width   = 2'd2;
        bus.data_read    = 1'b1;
        step;
        chk("stall.c1.mem_read", 64'(bus.mem_read), 64'h1);
        for (int i = 0; i < 5; i++) begin
            step;
            chk($sformatf("stall.w%0d.ready", i),
                64'(bus.data_ready), 64'h0);
            chk($sformatf("stall.w%0d.strobes", i),
                64'({bus.mem_read, bus.mem_write}), 64'h0);
        end
        bus.mem_rdata = 32'hCAFE_BABE;
        bus.mem_ready = 1'b1;
        step;
        chk("stall.ready", 64'(bus.data_ready), 64'h1);
        chk("stall.data", 64'(bus.data_out), 64'hCAFE_BABE);
        bus.data_read = 1'b0;
        step;

        // inputs change after grant; latched copy must be used
        bus.mem_ready    = 1'b0;
        bus.mem_rdata    = 32'hA1B2_C3D4;
        bus.data_address = 32'h803;
        bus.data_width   = 2'd0;
        bus.data_read    = 1'b1;
        step;
        bus.data_address = 32'h800;
        bus.data_width   = 2'd2;
        bus.mem_ready    = 1'b1;
        step;
        step;
        chk("latch.ready", 64'(bus.data_ready), 64'h1);
        chk("latch.data", 64'(bus.data_out), 64'hA1);
        bus.data_read = 1'b0;
        step;

        // reset during WAIT aborts the fetch
        bus.mem_ready     = 1'b0;
        bus.mem_rdata     = 32'h7777_7777;
        bus.instr_address = 32'h600;
        bus.instr_read    = 1'b1;
        step;
        chk("abort.c1.mem_read", 64'(bus.mem_read), 64'h1);
        step;
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        step;
        chk_zero("abort");
        reset          = 1'b0;
        bus.instr_read = 1'b0;
        step;
        chk("abort.c4.iready", 64'(bus.instr_ready), 64'h0);
        chk("abort.c4.mem_read", 64'(bus.mem_read), 64'h0);
        step;
        chk("abort.c5.iready", 64'(bus.instr_ready), 64'h0);
        chk("abort.c5.error", 64'(bus.data_error), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of all address ports.
REQ-002 Parameter DATA_W, fixed at 32, data width of all data ports.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 instr_address  in  ADDR_W  fetch address, word-aligned.
REQ-006 instr_read  in  1  fetch request; held high until instr_ready.
REQ-007 instr_value  out  32  fetched word; valid only while instr_ready is high.
REQ-008 instr_ready  out  1  one-cycle completion pulse for a fetch.
REQ-009 data_address  in  ADDR_W  load/store byte address.
REQ-010 data_width  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved.
REQ-011 data_read, data_write  in  1 each  load/store request; mutually exclusive; held until data_ready.
REQ-012 data_in  in  32  store data, right-aligned (lane 0).
REQ-013 data_out  out  32  load data, right-aligned, zero-extended; valid only while data_ready is high.
REQ-014 data_ready  out  1  one-cycle completion pulse for a load or store.
REQ-015 data_error  out  1  one-cycle pulse, in place of data_ready, for a misaligned or reserved-width request.
REQ-016 mem_address  out  ADDR_W  RAM word address; bits [1:0] driven zero.
REQ-017 mem_read, mem_write  out  1 each  one-cycle RAM strobes; never high together.
REQ-018 mem_byte_en  out  4  byte-lane write enables, valid with mem_write.
REQ-019 mem_wdata  out  32  lane-shifted store data.
REQ-020 mem_rdata  in  32  RAM read data, valid in the cycle mem_ready is high after mem_read.
REQ-021 mem_ready  in  1  RAM ready/completion indication.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs driven from registers.
REQ-023 IDLE: with a request pending, latch grant, address, width and lane data, then go to ISSUE; otherwise stay in IDLE.
REQ-024 ISSUE: assert exactly one strobe for exactly one cycle; a read goes to WAIT, a write goes to RESP.
REQ-025 WAIT: hold until mem_ready is high, capture mem_rdata into the response register, then go to RESP.
REQ-026 RESP: pulse the granted ready for one cycle, then go to IDLE; minimum latency from request to ready is 3 cycles for a read (ISSUE, WAIT, RESP) and 2 cycles for a write.
REQ-027 Byte enables: byte = 1<<a[1:0]; half = 4'b0011<<a[1:0]; word = 4'b1111; mem_wdata = data_in replicated across lanes.
REQ-028 Load data: shift right by 8*a[1:0], then mask to the width.
REQ-029 Half access with a[0]=1, word access with a[1:0]!=0, or width 3: no RAM strobe; go directly IDLE->RESP and pulse data_error instead of data_ready.
REQ-030 A requester that keeps its request high in the ready cycle starts a new transaction; that request is resampled in IDLE.
REQ-031 Changes to a latched request's inputs after grant have no effect on the transaction in flight.

Reset
REQ-032 Reset forces state IDLE and last_grant=INSTR, and zeroes every output in the cycle after the reset edge.
REQ-033 Reset mid-transaction aborts the transaction without any ready pulse; a RAM read already issued is discarded.

Configuration
REQ-034 When MEM_ARB_ROUND_ROBIN_EN is defined: on simultaneous requests, grant the requester not granted last; last_grant updates on every grant.
REQ-035 When MEM_ARB_ROUND_ROBIN_EN is undefined: data always wins simultaneous requests; last_grant logic is absent.

Structure
REQ-036 A shared package holds the state enum, the width encodings (WIDTH_BYTE/HALF/WORD), and the grant encoding (GRANT_INSTR/DATA).
REQ-037 Lane shift, mask and byte-enable generation live in one combinational sub-module, mem_lane_align.

Verification
REQ-038 Fetch of 0x100 only, RAM word 0x00000013, mem_ready=1 -> mem_read in cycle 1; instr_ready with 0x00000013 in cycle 3.
REQ-039 Byte store 0xAB to 0x203 -> mem_byte_en=4'b1000, mem_wdata=0xABABABAB, data_ready 2 cycles after the request.
REQ-040 Half load from 0x202, word 0x12345678 -> data_out=0x00001234; half load from 0x201 -> data_error pulse with no strobe.
REQ-041 Fetch and load both high for 4 transactions -> with the macro, grants alternate D,I,D,I; without it, D,D,D,D while data stays requested.
REQ-042 mem_ready held low for 5 cycles in WAIT -> no ready pulse and strobes stay low; ready pulses 1 cycle after mem_ready rises.
REQ-043 Reset asserted in the WAIT cycle -> no ready or error pulse, state IDLE, all outputs zero on the next cycle.
